// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, piece codes and controller states
package tetris_pkg;

    localparam int unsigned BOARD_W    = 10;
    localparam int unsigned BOARD_H    = 20;
    localparam int unsigned COORD_W    = $clog2((BOARD_W > BOARD_H) ? BOARD_W : BOARD_H);
    localparam int unsigned NUM_PIECES = 7;

    typedef enum logic [2:0] {
        PIECE_NONE = 3'd0,
        PIECE_I    = 3'd1,
        PIECE_O    = 3'd2,
        PIECE_T    = 3'd3,
        PIECE_S    = 3'd4,
        PIECE_Z    = 3'd5,
        PIECE_J    = 3'd6,
        PIECE_L    = 3'd7
    } piece_e;

    typedef enum logic [2:0] {
        ST_SPAWN,
        ST_FALL,
        ST_LOCK,
        ST_CLEAR,
        ST_OVER,
        ST_DROP
    } state_e;

    // Maps a raw random byte onto a legal piece code; code 0 is never produced.
    function automatic logic [2:0] piece_from_rand(input logic [7:0] r);
        logic [7:0] m;
        m = r % 8'(NUM_PIECES);
        return m[2:0] + 3'd1;
    endfunction

endpackage

// File: rtl/piece_lfsr.sv
// rtl/piece_lfsr.sv - free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), raw value out
module piece_lfsr
    import tetris_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Maximal-length polynomial: a non-zero seed never reaches the all-zero lock-up state.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/piece_ctrl.sv
// rtl/piece_ctrl.sv - falling-piece controller: moves, gravity, lock handshake, spawn, bomb
// Optional hard drop is built when PIECE_CTRL_HARD_DROP_EN is defined.
module piece_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned        GRAV_DIV  = 50_000_000,
    parameter logic [COORD_W-1:0] SPAWN_X   = 5'd3,
    parameter logic [COORD_W-1:0] SPAWN_Y   = 5'd0,
    parameter logic [7:0]         LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_rot,
    input  logic               btn_down,
    input  logic               btn_boom,
    input  logic               btn_hdrop,
    input  logic               el,
    input  logic               er,
    input  logic               eu,
    input  logic               edrop,
    input  logic               overflow,
    input  logic               refresh_done,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [2:0]         piece_type,
    output logic [1:0]         dir,
    output logic [2:0]         next_type,
    output logic               refresh,
    output logic               boom,
    output logic               game_over
);

    localparam int unsigned        CNT_W     = $clog2(GRAV_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(GRAV_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

    state_e             state_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [2:0]         type_q;
    logic [1:0]         dir_q;
    logic [2:0]         next_type_q;
    logic               refresh_q;
    logic               boom_q;
    logic               game_over_q;
    logic               ovf_q;
    logic               pending_q;
    logic [CNT_W-1:0]   grav_cnt_q;

    logic [7:0]         lfsr_val;
    logic               grav_tick;
    logic               drop_req;

    piece_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rstn),
        .value_o (lfsr_val)
    );

    assign grav_tick = (grav_cnt_q == CNT_MAX);
    assign drop_req  = btn_down | grav_tick | pending_q;

`ifndef PIECE_CTRL_HARD_DROP_EN
    logic unused_hdrop;
    assign unused_hdrop = btn_hdrop;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_SPAWN;
            x_q         <= SPAWN_X;
            y_q         <= SPAWN_Y;
            type_q      <= PIECE_I;
            dir_q       <= 2'd0;
            next_type_q <= piece_from_rand(LFSR_SEED);
            refresh_q   <= 1'b0;
            boom_q      <= 1'b0;
            game_over_q <= 1'b0;
            ovf_q       <= 1'b0;
            pending_q   <= 1'b0;
            grav_cnt_q  <= '0;
        end else begin
            refresh_q <= 1'b0;
            boom_q    <= 1'b0;
            case (state_q)
                ST_SPAWN: begin
                    type_q      <= next_type_q;
                    next_type_q <= piece_from_rand(lfsr_val);
                    x_q         <= SPAWN_X;
                    y_q         <= SPAWN_Y;
                    dir_q       <= 2'd0;
                    grav_cnt_q  <= '0;
                    pending_q   <= 1'b0;
                    state_q     <= ST_FALL;
                end
                ST_FALL: begin
                    grav_cnt_q <= grav_tick ? '0 : grav_cnt_q + CNT_ONE;
                    // A tick displaced by a higher-priority action is remembered, not lost.
                    pending_q  <= pending_q | grav_tick;
                    if (btn_boom) begin
                        boom_q <= 1'b1;
`ifdef PIECE_CTRL_HARD_DROP_EN
                    end else if (btn_hdrop) begin
                        pending_q <= 1'b0;
                        state_q   <= ST_DROP;
`endif
                    end else if (btn_rot && eu) begin
                        dir_q <= dir_q + 2'd1;
                    end else if (btn_left && el) begin
                        x_q <= x_q - COORD_ONE;
                    end else if (btn_right && er) begin
                        x_q <= x_q + COORD_ONE;
                    end else if (drop_req) begin
                        pending_q <= 1'b0;
                        if (edrop) begin
                            y_q        <= y_q + COORD_ONE;
                            grav_cnt_q <= '0;
                        end else begin
                            refresh_q <= 1'b1;
                            state_q   <= ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    ovf_q   <= overflow;
                    state_q <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    // Position and type stay frozen: the board reads them during merge.
                    if (refresh_done) begin
                        if (ovf_q) begin
                            game_over_q <= 1'b1;
                            state_q     <= ST_OVER;
                        end else begin
                            state_q <= ST_SPAWN;
                        end
                    end
                end
                ST_OVER: begin
                    state_q <= ST_OVER;
                end
`ifdef PIECE_CTRL_HARD_DROP_EN
                ST_DROP: begin
                    if (edrop) begin
                        y_q <= y_q + COORD_ONE;
                    end else begin
                        refresh_q <= 1'b1;
                        state_q   <= ST_LOCK;
                    end
                end
`endif
                default: begin
                    state_q <= ST_SPAWN;
                end
            endcase
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign piece_type = type_q;
    assign dir        = dir_q;
    assign next_type  = next_type_q;
    assign refresh    = refresh_q;
    assign boom       = boom_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_piece_ctrl.sv
// tb/tb_piece_ctrl.sv - randomized and directed bench for piece_ctrl against a behavioural model
module tb_piece_ctrl;

    localparam int G    = 4;
    localparam int SX   = 3;
    localparam int SY   = 0;
    localparam int SEED = 8'hA5;
`ifdef PIECE_CTRL_HARD_DROP_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    localparam int P_SPAWN = 0;
    localparam int P_FALL  = 1;
    localparam int P_LOCK  = 2;
    localparam int P_CLEAR = 3;
    localparam int P_OVER  = 4;
    localparam int P_DROP  = 5;

    logic       clk = 1'b0;
    logic       rstn;
    logic       btn_left, btn_right, btn_rot, btn_down, btn_boom, btn_hdrop;
    logic       el, er, eu, edrop, overflow, refresh_done;
    logic [4:0] x, y;
    logic [2:0] piece_type, next_type;
    logic [1:0] dir;
    logic       refresh, boom, game_over;

    piece_ctrl #(
        .GRAV_DIV (G)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_rot      (btn_rot),
        .btn_down     (btn_down),
        .btn_boom     (btn_boom),
        .btn_hdrop    (btn_hdrop),
        .el           (el),
        .er           (er),
        .eu           (eu),
        .edrop        (edrop),
        .overflow     (overflow),
        .refresh_done (refresh_done),
        .x            (x),
        .y            (y),
        .piece_type   (piece_type),
        .dir          (dir),
        .next_type    (next_type),
        .refresh      (refresh),
        .boom         (boom),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the controller, written from the game rules
    int m_ph, m_x, m_y, m_type, m_dir, m_next, m_cnt, m_lfsr;
    bit m_ref, m_boom, m_go, m_pend, m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int lfsr_adv(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    task automatic model_reset();
        m_ph = P_SPAWN; m_x = SX; m_y = SY; m_type = 1; m_dir = 0;
        m_next = SEED % 7 + 1; m_cnt = 0; m_lfsr = SEED;
        m_ref = 0; m_boom = 0; m_go = 0; m_pend = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit tick, req;
        int nl;
        nl = lfsr_adv(m_lfsr);
        m_ref = 0;
        m_boom = 0;
        case (m_ph)
            P_SPAWN: begin
                m_type = m_next; m_next = m_lfsr % 7 + 1;
                m_x = SX; m_y = SY; m_dir = 0; m_cnt = 0; m_pend = 0; m_ph = P_FALL;
            end
            P_FALL: begin
                tick  = (m_cnt == G - 1);
                m_cnt = (m_cnt + 1) % G;
                req   = btn_down || tick || m_pend;
                if (btn_boom) begin
                    m_boom = 1; m_pend = m_pend | tick;
                end else if (HD && btn_hdrop) begin
                    m_ph = P_DROP; m_pend = 0;
                end else if (btn_rot && eu) begin
                    m_dir = (m_dir + 1) % 4; m_pend = m_pend | tick;
                end else if (btn_left && el) begin
                    m_x = (m_x + 31) % 32; m_pend = m_pend | tick;
                end else if (btn_right && er) begin
                    m_x = (m_x + 1) % 32; m_pend = m_pend | tick;
                end else if (req) begin
                    m_pend = 0;
                    if (edrop) begin
                        m_y = (m_y + 1) % 32; m_cnt = 0;
                    end else begin
                        m_ph = P_LOCK; m_ref = 1;
                    end
                end
            end
            P_LOCK: begin
                m_ovf = overflow; m_ph = P_CLEAR;
            end
            P_CLEAR: begin
                if (refresh_done) begin
                    if (m_ovf) begin m_ph = P_OVER; m_go = 1; end
                    else m_ph = P_SPAWN;
                end
            end
            P_DROP: begin
                if (edrop) m_y = (m_y + 1) % 32;
                else begin m_ph = P_LOCK; m_ref = 1; end
            end
            default: ;
        endcase
        m_lfsr = nl;
    endtask

    task automatic compare_all();
        check("x", x, m_x);
        check("y", y, m_y);
        check("type", piece_type, m_type);
        check("dir", dir, m_dir);
        check("next_type", next_type, m_next);
        check("refresh", refresh, m_ref);
        check("boom", boom, m_boom);
        check("game_over", game_over, m_go);
    endtask

    task automatic clear_btns();
        btn_left = 0; btn_right = 0; btn_rot = 0; btn_down = 0; btn_boom = 0; btn_hdrop = 0;
    endtask

    task automatic tick_once();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 0;
        clear_btns();
        refresh_done = 0;
        overflow = 0;
        @(negedge clk);
        model_reset();
        compare_all();
        check("rst_type", piece_type, 1);
        check("rst_next", next_type, SEED % 7 + 1);
        check("rst_x", x, SX);
        rstn = 1;
    endtask

    task automatic wait_lock(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * G + 2 && !seen; i++) begin
            tick_once();
            seen = refresh;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        rstn = 0; clear_btns(); el = 0; er = 0; eu = 0; edrop = 0;
        overflow = 0; refresh_done = 0;
        @(negedge clk);

        // Reset and spawn, then gravity every G cycles
        do_reset();
        edrop = 1;
        tick_once();
        check("spawn_type", piece_type, SEED % 7 + 1);
        check("spawn_y", y, SY);
        repeat (4) tick_once();
        check("grav_y1", y, 1);
        repeat (4) tick_once();
        check("grav_y2", y, 2);

        // Move priority: rotation wins, disabled move is dropped
        btn_rot = 1; btn_left = 1; btn_right = 1; eu = 1; el = 1; er = 1;
        tick_once(); clear_btns();
        check("prio_dir", dir, 1);
        check("prio_x", x, SX);
        btn_left = 1; el = 0;
        tick_once(); clear_btns();
        check("blocked_left_x", x, SX);
        btn_left = 1; el = 1;
        tick_once(); clear_btns();
        check("left_x", x, SX - 1);

        // Lock handshake with board buttons ignored in CLEAR
        eu = 0; el = 0; er = 0; edrop = 0;
        wait_lock("lock_refresh");
        tick_once();
        check("refresh_one_cycle", refresh, 0);
        for (int i = 0; i < 5; i++) begin
            btn_boom = $urandom_range(0, 1); btn_left = 1; el = 1; btn_rot = 1; eu = 1;
            tick_once(); clear_btns();
        end
        check("clear_hold_x", x, SX - 1);
        check("clear_hold_y", y, 2);
        check("clear_hold_dir", dir, 1);
        el = 0; eu = 0;
        refresh_done = 1;
        tick_once();
        refresh_done = 0;
        edrop = 1;
        tick_once();
        check("respawn_y", y, SY);
        check("respawn_dir", dir, 0);

        // Game over on overflowing lock
        edrop = 0; overflow = 1;
        wait_lock("over_lock");
        tick_once();
        repeat (2) tick_once();
        refresh_done = 1;
        tick_once();
        refresh_done = 0; overflow = 0;
        check("game_over_set", game_over, 1);
        for (int i = 0; i < 10; i++) begin
            btn_left = 1; btn_right = 1; btn_down = 1; btn_boom = 1; el = 1; er = 1; edrop = 1;
            tick_once(); clear_btns();
        end
        check("game_over_sticky", game_over, 1);
        check("over_boom", boom, 0);
        el = 0; er = 0;

        // Boom on the gravity-tick cycle defers the drop by one cycle
        do_reset();
        edrop = 1;
        tick_once();
        repeat (3) tick_once();
        btn_boom = 1;
        tick_once(); clear_btns();
        check("boom_pulse", boom, 1);
        check("boom_y_held", y, 0);
        tick_once();
        check("boom_done", boom, 0);
        check("pending_y", y, 1);

        // Hard drop request
        btn_hdrop = 1;
        tick_once(); clear_btns();
        check("hdrop_y", y, 1);
`ifdef PIECE_CTRL_HARD_DROP_EN
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                edrop = (m_y < 17);
                tick_once();
                seen = refresh;
            end
            check("hdrop_lock", seen, 1);
            check("hdrop_final_y", y, 17);
        end
`endif

        // Randomized play against the model, including resets anywhere
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 399) == 0 || (m_go && $urandom_range(0, 19) == 0)) do_reset();
            btn_left     = ($urandom_range(0, 7) == 0);
            btn_right    = ($urandom_range(0, 7) == 0);
            btn_rot      = ($urandom_range(0, 7) == 0);
            btn_down     = ($urandom_range(0, 9) == 0);
            btn_boom     = ($urandom_range(0, 39) == 0);
            btn_hdrop    = ($urandom_range(0, 59) == 0);
            el           = ($urandom_range(0, 3) != 0) && (m_x > 0);
            er           = ($urandom_range(0, 3) != 0) && (m_x < 9);
            eu           = ($urandom_range(0, 1) != 0);
            edrop        = ($urandom_range(0, 5) != 0) && (m_y < 19);
            overflow     = ($urandom_range(0, 9) == 0);
            refresh_done = (m_ph == P_CLEAR) && ($urandom_range(0, 2) == 0);
            tick_once();
        end
        clear_btns();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
